// File: rtl/wbu_uart_pkg.sv
// ---------------------------------------------------------------------------
// wbu_uart_pkg
// Shared definitions for the debug-bus UART path: transmitter state
// encoding, baud counter width and the default bit period.
// ---------------------------------------------------------------------------
package wbu_uart_pkg;

    // Width of the baud down-counter; bit periods up to 2^24-1 clocks.
    localparam int BAUD_CW = 24;

    // 100 MHz system clock / 115200 baud.
    localparam logic [BAUD_CW-1:0] DEFAULT_CLOCKS_PER_BAUD = 24'd868;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4,
        ST_MARK  = 3'd5
    } tx_state_t;

endpackage

// File: rtl/wbu_sync2ff.sv
// ---------------------------------------------------------------------------
// wbu_sync2ff
// Two-flop synchronizer for a single asynchronous level input.
//   i_clk       in   destination clock
//   i_areset_n  in   asynchronous active-low reset
//   i_d         in   asynchronous input level
//   o_q         out  synchronized level (two clocks of latency)
// RESET_VAL selects the level both flops hold while in reset, so the
// consumer sees a safe value until real samples have propagated.
// ---------------------------------------------------------------------------
module wbu_sync2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_areset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/wbu_txuart.sv
// ---------------------------------------------------------------------------
// wbu_txuart
// 8N1 serial transmitter for the debug-bus console path, with optional CTS
// flow control and a line-break generator.
//   i_clk       in   system clock
//   i_areset_n  in   asynchronous active-low reset
//   i_wr        in   byte-valid strobe, held by upstream until accepted
//   i_data[7:0] in   byte to send, LSB first
//   i_break     in   hold the line low (break) while set
//   i_cts_n     in   clear-to-send, active-low, asynchronous
//   o_uart_tx   out  serial line, idle high (registered)
//   o_busy      out  registered; 1 = not accepting a byte this cycle
// A byte is accepted on any cycle with i_wr && !o_busy.
// ---------------------------------------------------------------------------
module wbu_txuart
    import wbu_uart_pkg::*;
#(
    parameter logic [BAUD_CW-1:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
    parameter logic               USE_CTS         = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_areset_n,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    input  logic       i_break,
    input  logic       i_cts_n,
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam logic [BAUD_CW-1:0] BAUD_RELOAD = CLOCKS_PER_BAUD - 24'd1;

    tx_state_t          r_state;
    tx_state_t          w_state_next;
    logic [BAUD_CW-1:0] r_baud;
    logic [BAUD_CW-1:0] w_baud_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_next;
    logic               r_tx;
    logic               w_tx_next;
    logic               r_busy;
    logic               w_busy_next;

    logic               w_cts_sync;
    logic               w_cts_block;
    logic               w_accept;
    logic               w_baud_done;
    logic               w_can_start;

    // Synchronizer resets to "blocked" so nothing is accepted until the
    // real CTS level has propagated.
    wbu_sync2ff #(
        .RESET_VAL (1'b1)
    ) u_cts_sync (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_d        (i_cts_n),
        .o_q        (w_cts_sync)
    );

    assign w_cts_block = USE_CTS && w_cts_sync;
    assign w_accept    = i_wr && !r_busy;
    assign w_baud_done = (r_baud == '0);
    // Conditions under which a new frame may begin on the next cycle.
    assign w_can_start = !w_cts_block && !i_break;

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = w_baud_done ? '0 : (r_baud - 24'd1);
        w_shift_next = r_shift;
        w_bit_next   = r_bit;

        case (r_state)
            ST_IDLE: begin
                // Accept beats break: a byte taken while not busy goes first.
                if (w_accept) begin
                    w_state_next = ST_START;
                    w_baud_next  = BAUD_RELOAD;
                    w_shift_next = i_data;
                end else if (i_break) begin
                    w_state_next = ST_BREAK;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_state_next = ST_DATA;
                    w_baud_next  = BAUD_RELOAD;
                    w_bit_next   = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_next = BAUD_RELOAD;
                    if (r_bit == 3'd7) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_next   = r_bit + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    // Accepting here chains frames with no idle gap.
                    if (w_accept) begin
                        w_state_next = ST_START;
                        w_baud_next  = BAUD_RELOAD;
                        w_shift_next = i_data;
                    end else if (i_break) begin
                        w_state_next = ST_BREAK;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (!i_break) begin
                    w_state_next = ST_MARK;
                    w_baud_next  = BAUD_RELOAD;
                end
            end
            ST_MARK: begin
                if (w_baud_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_baud_next  = '0;
            end
        endcase
    end

    // Line level follows the state being entered so o_uart_tx is a flop.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            ST_BREAK: w_tx_next = 1'b0;
            default:  w_tx_next = 1'b1;
        endcase
    end

    // Busy is computed one cycle ahead: low only for idle, or for the last
    // stop-bit cycle, and then only when a new frame could legally start.
    // Entering START always forces it high, so an accepted byte is never
    // taken twice.
    always_comb begin
        w_busy_next = 1'b1;
        if (w_can_start &&
            ((w_state_next == ST_IDLE) ||
             ((w_state_next == ST_STOP) && (w_baud_next == '0)))) begin
            w_busy_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
        end
    end

    assign o_uart_tx = r_tx;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_wbu_txuart.sv
// ---------------------------------------------------------------------------
// tb_wbu_txuart
// Bench for wbu_txuart at 4 clocks per bit. Two instances: u_dut honours
// CTS, u_dut_nc ignores it. Stimulus pushes expected bytes into per-DUT
// queues; a line monitor per DUT decodes frames and compares them.
// ---------------------------------------------------------------------------
module tb_wbu_txuart;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       wr0, brk0, cts_n0, tx0, busy0;
    logic [7:0] data0;
    logic       wr1, brk1, tx1, busy1;
    logic [7:0] data1;
    logic [1:0] tx_w;
    logic [1:0] brk_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frames0  = 0;
    int frames1  = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    assign tx_w  = {tx1, tx0};
    assign brk_w = {brk1, brk0};

    wbu_txuart #(
        .CLOCKS_PER_BAUD (24'd4),
        .USE_CTS         (1'b1)
    ) u_dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .i_wr       (wr0),
        .i_data     (data0),
        .i_break    (brk0),
        .i_cts_n    (cts_n0),
        .o_uart_tx  (tx0),
        .o_busy     (busy0)
    );

    wbu_txuart #(
        .CLOCKS_PER_BAUD (24'd4),
        .USE_CTS         (1'b0)
    ) u_dut_nc (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .i_wr       (wr1),
        .i_data     (data1),
        .i_break    (brk1),
        .i_cts_n    (1'b1),
        .o_uart_tx  (tx1),
        .o_busy     (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s bound expired (cycle %0d)", name, cyc);
    endtask

    // Line level expected k cycles into a frame (k=1 is the first start-bit cycle).
    function automatic logic exp_tx(input int k, input logic [7:0] d);
        if (k <= CPB)       return 1'b0;
        if (k <= 9 * CPB)   return d[(k - CPB - 1) / CPB];
        return 1'b1;
    endfunction

    // Called at a negedge with wr0 already asserted; returns the index of
    // the accepting posedge.
    task automatic wait_accept(output int a);
        int t;
        t = 0;
        a = -1;
        while (1) begin
            if (busy0 === 1'b0) begin
                a = cyc + 1;
                @(posedge clk);
                return;
            end
            @(negedge clk);
            t++;
            if (t > 300) begin
                fail_now("accept_timeout");
                return;
            end
        end
    endtask

    task automatic wait_idle0();
        int t;
        t = 0;
        while (busy0 !== 1'b0) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                fail_now("idle_timeout");
                return;
            end
        end
    endtask

    // Decodes frames on DUT 'id' sampling every cycle on the falling edge;
    // every bit must hold for exactly CPB cycles.
    task automatic monitor(input int id);
        logic       line[40];
        logic       ok;
        logic       aborted;
        logic [7:0] b;
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_w[id] === 1'b0) begin
                if (brk_w[id] === 1'b1) begin
                    while (tx_w[id] === 1'b0) @(negedge clk);
                    continue;
                end
                aborted = 1'b0;
                line[0] = 1'b0;
                for (int c = 1; c < 10 * CPB; c++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    line[c] = tx_w[id];
                end
                if (aborted) continue;
                ok = 1'b1;
                for (int c = 0; c < CPB; c++) if (line[c] !== 1'b0) ok = 1'b0;
                for (int c = 9 * CPB; c < 10 * CPB; c++) if (line[c] !== 1'b1) ok = 1'b0;
                for (int bi = 0; bi < 8; bi++) begin
                    b[bi] = line[CPB + CPB * bi];
                    for (int j = 1; j < CPB; j++)
                        if (line[CPB + CPB * bi + j] !== b[bi]) ok = 1'b0;
                end
                if (id == 0) begin
                    frames0++;
                    exp = (q0.size() > 0) ? {1'b0, q0.pop_front()} : 9'h100;
                end else begin
                    frames1++;
                    exp = (q1.size() > 0) ? {1'b0, q1.pop_front()} : 9'h100;
                end
                $display("dut%0d frame byte=%02h expected=%03h", id, b, exp);
                chk("frame_shape", {31'd0, ok}, 32'd1);
                chk("frame_byte", {23'd0, 1'b0, b}, {23'd0, exp});
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #500000;
        fail_now("watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        int a, a1, a2, lat, t;
        logic pend, ok;

        rst_n = 1'b0; wr0 = 1'b0; data0 = 8'h00; brk0 = 1'b0; cts_n0 = 1'b0;
        wr1 = 1'b0; data1 = 8'h00; brk1 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx0", {31'd0, tx0}, 32'd1);
        chk("rst_busy0", {31'd0, busy0}, 32'd1);
        chk("rst_tx1", {31'd0, tx1}, 32'd1);
        chk("rst_busy1", {31'd0, busy1}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("sync_busy0", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        chk("nocts_busy1", {31'd0, busy1}, 32'd0);
        wait_idle0();

        // USE_CTS=0 instance, CTS tied high: 0x3C must go out
        wr1 = 1'b1; data1 = 8'h3C;
        t = 0;
        while (busy1 !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) fail_now("nc_accept_timeout");
        else begin
            @(posedge clk);
            q1.push_back(8'h3C);
        end
        @(negedge clk);
        wr1 = 1'b0;
        repeat (45) @(negedge clk);

        // Single byte 0xA5: exact line and busy per cycle
        wr0 = 1'b1; data0 = 8'hA5;
        wait_accept(a);
        q0.push_back(8'hA5);
        for (int k = 1; k <= 10 * CPB; k++) begin
            @(negedge clk);
            if (k == 1) wr0 = 1'b0;
            chk($sformatf("single_tx_k%0d", k), {31'd0, tx0}, {31'd0, exp_tx(k, 8'hA5)});
            if (k == 1 || k == 39 || k == 40)
                chk($sformatf("single_busy_k%0d", k), {31'd0, busy0}, (k == 40) ? 32'd0 : 32'd1);
        end
        repeat (3) @(negedge clk);

        // Back-to-back 0x00 then 0xFF with strobe held
        wr0 = 1'b1; data0 = 8'h00;
        wait_accept(a1);
        q0.push_back(8'h00);
        @(negedge clk);
        data0 = 8'hFF;
        wait_accept(a2);
        q0.push_back(8'hFF);
        @(negedge clk);
        wr0 = 1'b0;
        chk("b2b_accept_gap", a2 - a1, 32'd40);
        chk("b2b_second_start", {31'd0, tx0}, 32'd0);
        @(negedge clk);
        wait_idle0();
        repeat (3) @(negedge clk);

        // CTS blocking, release latency, and deassert mid-frame
        cts_n0 = 1'b1;
        repeat (5) @(negedge clk);
        chk("cts_block_busy", {31'd0, busy0}, 32'd1);
        wr0 = 1'b1; data0 = 8'h55;
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b1) ok = 1'b0;
        end
        chk("cts_hold", {31'd0, ok}, 32'd1);
        cts_n0 = 1'b0;
        pend = 1'b0;
        lat = 99;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (pend) begin wr0 = 1'b0; pend = 1'b0; end
            if (busy0 === 1'b0 && wr0) begin pend = 1'b1; q0.push_back(8'h55); end
            if (tx0 === 1'b0) begin lat = k; break; end
        end
        wr0 = 1'b0;
        chk("cts_latency_ok", {31'd0, (lat >= 3 && lat <= 4)}, 32'd1);
        repeat (8) @(negedge clk);
        cts_n0 = 1'b1;
        repeat (35) @(negedge clk);
        chk("cts_post_busy", {31'd0, busy0}, 32'd1);
        chk("cts_post_tx", {31'd0, tx0}, 32'd1);
        cts_n0 = 1'b0;
        wait_idle0();
        repeat (3) @(negedge clk);

        // Break raised mid-frame for 50 cycles
        wr0 = 1'b1; data0 = 8'h81;
        wait_accept(a);
        q0.push_back(8'h81);
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (k == 1) wr0 = 1'b0;
            if (k >= 37 && k <= 40)
                chk($sformatf("brk_stop_k%0d", k), {31'd0, tx0}, 32'd1);
            if (k == 40)
                chk("brk_stop_busy", {31'd0, busy0}, 32'd1);
            if (k >= 41 && k <= 60)
                chk($sformatf("brk_low_k%0d", k), {31'd0, tx0}, 32'd0);
            if (k >= 61 && k <= 64) begin
                chk($sformatf("brk_mark_k%0d", k), {31'd0, tx0}, 32'd1);
                chk($sformatf("brk_mark_busy_k%0d", k), {31'd0, busy0}, 32'd1);
            end
            if (k == 65)
                chk("brk_done_busy", {31'd0, busy0}, 32'd0);
            if (k == 10) brk0 = 1'b1;
            if (k == 60) brk0 = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0xC3 (bit 3 = 0)
        wr0 = 1'b1; data0 = 8'hC3;
        wait_accept(a);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) wr0 = 1'b0;
        end
        chk("rst_pre_tx", {31'd0, tx0}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", {31'd0, tx0}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy0}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_busy", {31'd0, busy0}, 32'd1);
        wait_idle0();
        wr0 = 1'b1; data0 = 8'h5A;
        wait_accept(a);
        q0.push_back(8'h5A);
        @(negedge clk);
        wr0 = 1'b0;
        repeat (50) @(negedge clk);

        // Every byte accounted for, nothing extra
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        chk("frames0", frames0, 32'd6);
        chk("frames1", frames1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
